bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 33 +++
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Two-requester shared-bus bundle; "master" is the arbiter's view, "slave" the requester/decoder view.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_a;
    logic [31:0] m1_a;
    logic [31:0] m0_wd;
    logic [31:0] m1_wd;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_done;
    logic        m1_done;
    logic [31:0] m0_rd;
    logic [31:0] m1_rd;
    logic        bus_we;
    logic [31:0] bus_a;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        bus_ready;
    logic        err;

    modport master (
        input  m0_req, m1_req, m0_we, m1_we, m0_a, m1_a, m0_wd, m1_wd, bus_rd, bus_ready,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_rd, m1_rd, bus_we, bus_a, bus_wd, err
    );

    modport slave (
        output m0_req, m1_req, m0_we, m1_we, m0_a, m1_a, m0_wd, m1_wd, bus_rd, bus_ready,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rd, m1_rd, bus_we, bus_a, bus_wd, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with registered read data and done pulses.
// Optional ARB_TIMEOUT_EN: abandons a stalled transaction after TIMEOUT cycles and sets sticky err.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst_n,
    bus_arbiter_if.master arb
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;      // 1: m1 was served last
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic [1:0]  done_q, done_d;

    logic        own;
    logic        sel;
    logic        cur_req;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    assign own     = (state_q != StIdle);
    assign sel     = (state_q == StOwn1);
    assign cur_req = sel ? arb.m1_req : arb.m0_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        done_d  = 2'b00;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        if (!own) begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (arb.m0_req && arb.m1_req) begin
                state_d = last_q ? StOwn0 : StOwn1;
            end else if (arb.m0_req) begin
                state_d = StOwn0;
            end else if (arb.m1_req) begin
                state_d = StOwn1;
            end
        end else if (!cur_req) begin
            // Requester withdrew: abort silently, leave rd and last-served alone.
            state_d = StIdle;
        end else if (arb.bus_ready) begin
            state_d     = StIdle;
            last_d      = sel;
            done_d[sel] = 1'b1;
            if (sel) rd1_d = arb.bus_rd;
            else     rd0_d = arb.bus_rd;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d     = StIdle;
            last_d      = sel;
            done_d[sel] = 1'b1;
            err_d       = 1'b1;
            if (sel) rd1_d = 32'hDEAD_BEEF;
            else     rd0_d = 32'hDEAD_BEEF;
        end else begin
            cnt_d = cnt_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            rd0_q   <= '0;
            rd1_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            done_q  <= done_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign arb.err = err_q;
`else
    assign arb.err = 1'b0;
`endif

    always_comb begin
        arb.m0_gnt  = (state_q == StOwn0);
        arb.m1_gnt  = (state_q == StOwn1);
        arb.m0_done = done_q[0];
        arb.m1_done = done_q[1];
        arb.m0_rd   = rd0_q;
        arb.m1_rd   = rd1_q;
        arb.bus_we  = 1'b0;
        arb.bus_a   = '0;
        arb.bus_wd  = '0;
        unique case (state_q)
            StOwn0: begin
                arb.bus_we = arb.m0_we;
                arb.bus_a  = arb.m0_a;
                arb.bus_wd = arb.m0_wd;
            end
            StOwn1: begin
                arb.bus_we = arb.m1_we;
                arb.bus_a  = arb.m1_a;
                arb.bus_wd = arb.m1_wd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; the timeout scenario runs only with ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bus_arbiter_if bif ();

    bus_arbiter #(.TIMEOUT(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arb  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bif.m0_req = 0; bif.m1_req = 0; bif.m0_we = 0; bif.m1_we = 0;
        bif.m0_a = 0; bif.m1_a = 0; bif.m0_wd = 0; bif.m1_wd = 0;
        bif.bus_rd = 0; bif.bus_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bif.m0_gnt, bif.m1_gnt, bif.m0_done, bif.m1_done, bif.err, bif.bus_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bif.m0_gnt, bif.m1_gnt, bif.m0_done, bif.m1_done, bif.err, bif.bus_we});
        end
        vectors++;
        if (bif.m0_rd !== 32'h0 || bif.m1_rd !== 32'h0 || bif.bus_a !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: rd0=%h rd1=%h bus_a=%h want 0", bif.m0_rd, bif.m1_rd,
                     bif.bus_a);
        end
        rst_n = 1'b1;
        // bus_ready high while idle must not produce a completion
        @(negedge clk);
        vectors++;
        if (bif.m0_done !== 1'b0 || bif.m1_done !== 1'b0 || bif.m0_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready_ignored: done=%b%b gnt0=%b want 000", bif.m0_done,
                     bif.m1_done, bif.m0_gnt);
        end
        bif.bus_ready = 1'b0;
    endtask

    task automatic test_single_read();
        bif.m0_req = 1; bif.m0_a = 32'h0000_0004;
        bif.bus_rd = 32'h1234_5678; bif.bus_ready = 1;
        @(negedge clk);
        vectors++;
        if (bif.m0_gnt !== 1'b1 || bif.m1_gnt !== 1'b0 || bif.bus_a !== 32'h4
            || bif.m0_done !== 1'b0) begin
            miscompares++;
            $display("FAIL read_grant: gnt=%b%b bus_a=%h done=%b want 10/00000004/0",
                     bif.m0_gnt, bif.m1_gnt, bif.bus_a, bif.m0_done);
        end
        @(negedge clk);
        vectors++;
        if (bif.m0_done !== 1'b1 || bif.m0_gnt !== 1'b0 || bif.m0_rd !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL read_done: done=%b gnt=%b rd=%h want 1/0/12345678", bif.m0_done,
                     bif.m0_gnt, bif.m0_rd);
        end
        bif.m0_req = 0; bif.bus_rd = 32'h0; bif.bus_ready = 0;
        @(negedge clk);
        vectors++;
        if (bif.m0_done !== 1'b0 || bif.m0_gnt !== 1'b0 || bif.m0_rd !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL read_hold: done=%b gnt=%b rd=%h want 0/0/12345678", bif.m0_done,
                     bif.m0_gnt, bif.m0_rd);
        end
    endtask

    task automatic test_write_pass();
        bif.m1_we = 1; bif.m1_a = 32'h0000_0800; bif.m1_wd = 32'd5;
        #1;
        vectors++;
        if (bif.bus_we !== 1'b0 || bif.bus_a !== 32'h0 || bif.bus_wd !== 32'h0) begin
            miscompares++;
            $display("FAIL write_idle_bus: we=%b a=%h wd=%h want 0/0/0", bif.bus_we, bif.bus_a,
                     bif.bus_wd);
        end
        bif.m1_req = 1;
        @(negedge clk);
        vectors++;
        if (bif.m1_gnt !== 1'b1 || bif.bus_we !== 1'b1 || bif.bus_a !== 32'h800
            || bif.bus_wd !== 32'd5) begin
            miscompares++;
            $display("FAIL write_pass: gnt=%b we=%b a=%h wd=%h want 1/1/00000800/5", bif.m1_gnt,
                     bif.bus_we, bif.bus_a, bif.bus_wd);
        end
        bif.bus_ready = 1;
        @(negedge clk);
        vectors++;
        if (bif.m1_done !== 1'b1 || bif.m1_gnt !== 1'b0 || bif.bus_we !== 1'b0
            || bif.bus_a !== 32'h0) begin
            miscompares++;
            $display("FAIL write_done: done=%b gnt=%b we=%b a=%h want 1/0/0/0", bif.m1_done,
                     bif.m1_gnt, bif.bus_we, bif.bus_a);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g0;
        logic [7:0] exp_g1;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
        int         n0;
        int         n1;
        logic [31:0] exp_a;
        // bit i = cycle i after both requests rise; m1 was served last, so m0 wins first
        exp_g0 = 8'b0001_0001;
        exp_g1 = 8'b0100_0100;
        exp_d0 = 8'b0010_0010;
        exp_d1 = 8'b1000_1000;
        n0 = 0; n1 = 0;
        bif.m0_a = 32'h10; bif.m1_a = 32'h20;
        bif.bus_rd = 32'hA5A5_0001; bif.bus_ready = 1;
        bif.m0_req = 1; bif.m1_req = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_a = exp_g0[i] ? 32'h10 : (exp_g1[i] ? 32'h20 : 32'h0);
            vectors++;
            if (bif.m0_gnt !== exp_g0[i] || bif.m1_gnt !== exp_g1[i]
                || bif.m0_done !== exp_d0[i] || bif.m1_done !== exp_d1[i]
                || bif.bus_a !== exp_a) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: gnt=%b%b done=%b%b a=%h want %b%b %b%b %h", i,
                         bif.m0_gnt, bif.m1_gnt, bif.m0_done, bif.m1_done, bif.bus_a,
                         exp_g0[i], exp_g1[i], exp_d0[i], exp_d1[i], exp_a);
            end
            if (bif.m0_done) n0++;
            if (bif.m1_done) n1++;
            if (n0 == 2) bif.m0_req = 0;
            if (n1 == 2) bif.m1_req = 0;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_abort();
        bif.m0_req = 1; bif.bus_ready = 0;
        @(negedge clk);
        bif.m1_req = 1;
        @(negedge clk);
        vectors++;
        if (bif.m0_gnt !== 1'b1 || bif.m1_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_holdoff: gnt=%b%b want 10", bif.m0_gnt, bif.m1_gnt);
        end
        bif.m0_req = 0; bif.bus_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        vectors++;
        if (bif.m0_gnt !== 1'b0 || bif.m1_gnt !== 1'b0 || bif.m0_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: gnt=%b%b done0=%b want 00/0", bif.m0_gnt, bif.m1_gnt,
                     bif.m0_done);
        end
        @(negedge clk);
        vectors++;
        if (bif.m1_gnt !== 1'b1 || bif.m0_done !== 1'b0 || bif.m0_rd !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL abort_pending: gnt1=%b done0=%b rd0=%h want 1/0/a5a50001",
                     bif.m1_gnt, bif.m0_done, bif.m0_rd);
        end
        bif.bus_ready = 1;
        @(negedge clk);
        vectors++;
        if (bif.m1_done !== 1'b1 || bif.m1_rd !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL abort_m1_done: done=%b rd=%h want 1/ffffffff", bif.m1_done,
                     bif.m1_rd);
        end
        idle_inputs();
        @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bad = 0;
        bif.m1_req = 1; bif.bus_ready = 0; bif.bus_rd = 32'h0BAD_0BAD;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bif.m1_gnt !== 1'b1 || bif.m1_done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL timeout_wait: %0d cycles lost grant early, want 0", bad);
        end
        @(negedge clk);
        vectors++;
        if (bif.m1_done !== 1'b1 || bif.m1_gnt !== 1'b0 || bif.m1_rd !== 32'hDEAD_BEEF
            || bif.err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: done=%b gnt=%b rd=%h err=%b want 1/0/deadbeef/1",
                     bif.m1_done, bif.m1_gnt, bif.m1_rd, bif.err);
        end
        bif.m1_req = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bif.err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: err=%b want 1", bif.err);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_async_reset();
        bif.m0_req = 1; bif.m0_we = 1; bif.bus_ready = 0;
        @(negedge clk);
        vectors++;
        if (bif.m0_gnt !== 1'b1 || bif.bus_we !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: gnt=%b we=%b want 1/1", bif.m0_gnt, bif.bus_we);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bif.m0_gnt !== 1'b0 || bif.bus_we !== 1'b0 || bif.err !== 1'b0
            || bif.m0_done !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_drop: gnt=%b we=%b err=%b done=%b want 0000", bif.m0_gnt,
                     bif.bus_we, bif.err, bif.m0_done);
        end
        @(negedge clk);
        // tie right after reset must go to m0
        bif.m1_req = 1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bif.m0_gnt !== 1'b1 || bif.m1_gnt !== 1'b0 || bif.m0_done !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_resume: gnt=%b%b done=%b want 10/0", bif.m0_gnt, bif.m1_gnt,
                     bif.m0_done);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_write_pass();
        test_round_robin();
        test_abort();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
